// File: rtl/jtframe_cenmulti.sv
// Multi-channel fractional clock-enable generator: channel k pulses num[k]/den[k] of the clk rate.
// Define JTFRAME_CEN_RECOVER_EN to replay pulses lost under stall from a saturating per-channel counter.
module jtframe_cenmulti #(
    parameter int CH = 4,
    parameter int W  = 10,
    parameter int RW = 4
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [CH*W-1:0]   num,
    input  logic [CH*W-1:0]   den,
    input  logic              sync,
    input  logic [CH-1:0]     stall,
    output logic [CH-1:0]     cen,
    output logic [CH-1:0]     miss
);

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            logic [W-1:0] w_num;
            logic [W-1:0] w_den;
            logic [W:0]   w_sum;
            logic [W:0]   w_acc_next;
            logic         w_en;
            logic         w_full;
            logic         w_nat;
            logic [W:0]   r_acc;
            logic         r_cen;
            logic         r_miss;

            assign w_num  = num[gi*W +: W];
            assign w_den  = den[gi*W +: W];
            assign w_sum  = r_acc + {1'b0, w_num};
            assign w_en   = (w_den != '0);
            assign w_full = w_en && (w_num >= w_den);
            assign w_nat  = w_en && (w_sum >= {1'b0, w_den});

            // A ratio of one or more pulses every cycle; pinning acc at 0 keeps it from growing.
            always_comb begin
                w_acc_next = w_sum;
                if (!w_en || w_full)
                    w_acc_next = '0;
                else if (w_nat)
                    w_acc_next = w_sum - {1'b0, w_den};
            end

`ifdef JTFRAME_CEN_RECOVER_EN
            logic [RW-1:0] r_pend;
            logic          w_pend_sat;
            logic          w_pend_nz;

            assign w_pend_sat = &r_pend;
            assign w_pend_nz  = |r_pend;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc  <= '0;
                    r_cen  <= 1'b0;
                    r_miss <= 1'b0;
                    r_pend <= '0;
                end else if (sync || !w_en) begin
                    r_acc  <= '0;
                    r_cen  <= 1'b0;
                    r_miss <= 1'b0;
                end else begin
                    r_acc <= w_acc_next;
                    if (stall[gi]) begin
                        r_cen  <= 1'b0;
                        r_miss <= w_nat && w_pend_sat;
                        if (w_nat && !w_pend_sat)
                            r_pend <= r_pend + 1'b1;
                    end else begin
                        // Replays only fill cycles without a natural pulse, so none is merged away.
                        r_cen  <= w_nat || w_pend_nz;
                        r_miss <= 1'b0;
                        if (w_pend_nz && !w_nat)
                            r_pend <= r_pend - 1'b1;
                    end
                end
            end
`else
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_acc  <= '0;
                    r_cen  <= 1'b0;
                    r_miss <= 1'b0;
                end else if (sync || !w_en) begin
                    r_acc  <= '0;
                    r_cen  <= 1'b0;
                    r_miss <= 1'b0;
                end else begin
                    r_acc <= w_acc_next;
                    if (stall[gi]) begin
                        r_cen  <= 1'b0;
                        r_miss <= w_nat;
                    end else begin
                        r_cen  <= w_nat;
                        r_miss <= 1'b0;
                    end
                end
            end
`endif

            assign cen[gi]  = r_cen;
            assign miss[gi] = r_miss;
        end
    endgenerate

endmodule

// File: tb/tb_jtframe_cenmulti.sv
// Directed bench for jtframe_cenmulti: a per-cycle vector table plus multi-cycle scenario sequences.
module tb_jtframe_cenmulti;

    localparam int CH = 4;
    localparam int W  = 10;

    logic            clk;
    logic            rst;
    logic [CH*W-1:0] num;
    logic [CH*W-1:0] den;
    logic            sync;
    logic [CH-1:0]   stall;
    logic [CH-1:0]   cen;
    logic [CH-1:0]   miss;

    int n_cmp;
    int n_fail;

    jtframe_cenmulti #(.CH(CH), .W(W), .RW(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .num   (num),
        .den   (den),
        .sync  (sync),
        .stall (stall),
        .cen   (cen),
        .miss  (miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            sync;
        logic [CH-1:0]   stall;
        logic [CH*W-1:0] num;
        logic [CH*W-1:0] den;
        logic [CH-1:0]   exp_cen;
        logic [CH-1:0]   exp_miss;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [CH*W-1:0] pack4(input int a3, input int a2, input int a1, input int a0);
        logic [CH*W-1:0] v;
        v = '0;
        v[0*W +: W] = W'(a0);
        v[1*W +: W] = W'(a1);
        v[2*W +: W] = W'(a2);
        v[3*W +: W] = W'(a3);
        return v;
    endfunction

    task automatic push(input logic r, input logic s, input logic [CH-1:0] st,
                        input logic [CH*W-1:0] n, input logic [CH*W-1:0] d,
                        input logic [CH-1:0] ec, input logic [CH-1:0] em);
        vec_t v;
        v.rst = r; v.sync = s; v.stall = st; v.num = n; v.den = d;
        v.exp_cen = ec; v.exp_miss = em;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sync = 1'b0; stall = '0;
        step();
        rst = 1'b0;
    endtask

    logic [CH*W-1:0] n_a, d_a, d_b;
    int cnt, bad, last, maxgap, mingap, errs, nstall_cen, nmiss, nafter;

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; sync = 1'b0; stall = '0; num = '0; den = '0;

        // ch0 1/4, ch1 0/3 (never), ch2 5/5 (every cycle), ch3 disabled
        n_a = pack4(7, 5, 0, 1);
        d_a = pack4(0, 5, 3, 4);
        d_b = pack4(0, 0, 3, 4);
        push(1, 0, 4'b0000, n_a, d_a, 4'b0000, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_a, 4'b0100, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_a, 4'b0100, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_a, 4'b0100, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_a, 4'b0101, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_a, 4'b0100, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_a, 4'b0100, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_a, 4'b0100, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_a, 4'b0101, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_b, 4'b0000, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_b, 4'b0000, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_b, 4'b0000, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_b, 4'b0001, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_b, 4'b0000, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_b, 4'b0000, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_b, 4'b0000, 4'b0000);
`ifdef JTFRAME_CEN_RECOVER_EN
        push(0, 0, 4'b0001, n_a, d_b, 4'b0000, 4'b0000);
        push(0, 0, 4'b0000, n_a, d_b, 4'b0001, 4'b0000);
`else
        push(0, 0, 4'b0001, n_a, d_b, 4'b0000, 4'b0001);
        push(0, 0, 4'b0000, n_a, d_b, 4'b0000, 4'b0000);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; sync = vecs[i].sync; stall = vecs[i].stall;
            num = vecs[i].num; den = vecs[i].den;
            step();
            check($sformatf("vec%0d_cen", i), int'(cen), int'(vecs[i].exp_cen));
            check($sformatf("vec%0d_miss", i), int'(miss), int'(vecs[i].exp_miss));
        end

        // 1/4 over 100 cycles: pulses exactly on multiples of 4
        num = pack4(0, 0, 0, 1); den = pack4(0, 0, 0, 4);
        do_reset();
        cnt = 0; bad = 0;
        for (int n = 1; n <= 100; n++) begin
            step();
            if (cen[0]) cnt++;
            if (cen[0] != ((n % 4) == 0)) bad++;
        end
        check("r14_count", cnt, 25);
        check("r14_phase_errs", bad, 0);

        // 3/8 over 800 cycles against floor(3n/8)
        num = pack4(0, 0, 3, 0); den = pack4(0, 0, 8, 0);
        do_reset();
        cnt = 0; errs = 0; last = 0; maxgap = 0; mingap = 1000;
        for (int n = 1; n <= 800; n++) begin
            step();
            if (cen[1]) begin
                cnt++;
                if (last != 0) begin
                    if (n - last > maxgap) maxgap = n - last;
                    if (n - last < mingap) mingap = n - last;
                end
                last = n;
            end
            if (cnt != (3 * n) / 8) errs++;
        end
        check("r38_count", cnt, 300);
        check("r38_cum_errs", errs, 0);
        check("r38_maxgap", maxgap, 3);
        check("r38_mingap", mingap, 2);

        // sync on cycle 7 with ch0 1/2 and ch2 5/5
        num = pack4(0, 5, 0, 1); den = pack4(0, 5, 0, 2);
        do_reset();
        for (int n = 1; n <= 12; n++) begin
            sync = (n == 7);
            step();
            if (n >= 7)
                check($sformatf("sync_c%0d_cen0", n), int'(cen[0]), ((n == 9) || (n == 11)) ? 1 : 0);
            check($sformatf("sync_c%0d_cen2", n), int'(cen[2]), (n == 7) ? 0 : 1);
        end
        sync = 1'b0;

        // ch3 1/2 stalled for cycles 3..12
        num = pack4(1, 0, 0, 0); den = pack4(2, 0, 0, 0);
        do_reset();
        nstall_cen = 0; nmiss = 0; nafter = 0;
        for (int n = 1; n <= 23; n++) begin
            stall = ((n >= 3) && (n <= 12)) ? 4'b1000 : 4'b0000;
            step();
            if (stall[3] && cen[3]) nstall_cen++;
            if (miss[3]) nmiss++;
            if ((n >= 13) && (n <= 22) && cen[3]) nafter++;
            if (n == 13) begin
`ifdef JTFRAME_CEN_RECOVER_EN
                check("stall_c13_cen3", int'(cen[3]), 1);
`else
                check("stall_c13_cen3", int'(cen[3]), 0);
`endif
            end
            if (n == 23) check("stall_c23_cen3", int'(cen[3]), 0);
        end
        check("stall_cen_during", nstall_cen, 0);
`ifdef JTFRAME_CEN_RECOVER_EN
        check("stall_miss_total", nmiss, 0);
        check("stall_cen_after", nafter, 10);
`else
        check("stall_miss_total", nmiss, 5);
        check("stall_cen_after", nafter, 5);
`endif

        // reset mid-run after three lost ch3 pulses; restart must be clean
        num = pack4(1, 0, 0, 1); den = pack4(2, 0, 0, 4);
        do_reset();
        for (int n = 1; n <= 8; n++) begin
            stall = (n >= 3) ? 4'b1000 : 4'b0000;
            step();
        end
        rst = 1'b1;
        step();
        check("midrst_cen", int'(cen), 0);
        check("midrst_miss", int'(miss), 0);
        rst = 1'b0; stall = '0;
        for (int n = 1; n <= 4; n++) begin
            step();
            check($sformatf("restart_c%0d_cen0", n), int'(cen[0]), (n == 4) ? 1 : 0);
            if (n <= 2)
                check($sformatf("restart_c%0d_cen3", n), int'(cen[3]), (n == 2) ? 1 : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
